// File: rtl/echo_pkg.sv
// Shared types and constants for the echo indication serializer.
// ECHO_SER_HEADER_EN adds the HDR state to the serializer state enum.
package echo_pkg;

    localparam int WORD_W_DEF = 32;
    localparam logic [15:0] HDR_LEN = 16'd3;

`ifdef ECHO_SER_HEADER_EN
    typedef enum logic [2:0] {IDLE, HDR, W0, W1, W2} ser_state_e;
`else
    typedef enum logic [2:0] {IDLE, W0, W1, W2} ser_state_e;
`endif

endpackage

// File: rtl/echo_msg_fifo.sv
// Circular message buffer: DEPTH entries of WIDTH bits, head visible combinationally.
// Control (pointers, count) is reset; storage is not.
module echo_msg_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       deq,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_enq;
    logic             do_deq;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq & ~full;
    assign do_deq   = deq & ~empty;
    assign deq_data = mem[rptr];

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_enq) wptr <= wptr + 1'b1;
            if (do_deq) rptr <= rptr + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_enq) mem[wptr] <= enq_data;
    end

endmodule

// File: rtl/echo_indication_serializer.sv
// Buffers {v, meth, tag} indication messages and emits them as WORD_W words (tag first).
// Define ECHO_SER_HEADER_EN to prefix each message with a {3, seq} header word.
module echo_indication_serializer
    import echo_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  pipe_enq__ENA,
    input  logic [3*WORD_W-1:0]   pipe_enq_v,
    output logic                  pipe_enq__RDY,
    output logic                  out_enq__ENA,
    output logic [WORD_W-1:0]     out_enq_v,
    output logic                  out_enq_last,
    input  logic                  out_enq__RDY
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef ECHO_SER_HEADER_EN
    localparam ser_state_e FIRST = HDR;
`else
    localparam ser_state_e FIRST = W0;
`endif

    ser_state_e          state;
    ser_state_e          state_nxt;
    logic [3*WORD_W-1:0] head;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;
    logic                xfer;
    logic                pop;

    echo_msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3*WORD_W)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq      (pipe_enq__ENA),
        .enq_data (pipe_enq_v),
        .deq      (pop),
        .deq_data (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign pipe_enq__RDY = ~full;

    // Outputs are forced quiet while reset is held so nothing leaks mid-reset
    assign xfer         = nRST & (state != IDLE) & out_enq__RDY;
    assign pop          = xfer & (state == W2);
    assign out_enq__ENA = xfer;
    assign out_enq_last = nRST & (state == W2);

`ifdef ECHO_SER_HEADER_EN
    logic [15:0] seq;

    always_ff @(posedge CLK) begin
        if (!nRST)    seq <= '0;
        else if (pop) seq <= seq + 16'd1;
    end
`endif

    always_comb begin
        out_enq_v = '0;
        if (nRST) begin
            case (state)
`ifdef ECHO_SER_HEADER_EN
                HDR:     out_enq_v = WORD_W'({HDR_LEN, seq});
`endif
                W0:      out_enq_v = head[WORD_W-1:0];
                W1:      out_enq_v = head[2*WORD_W-1:WORD_W];
                W2:      out_enq_v = head[3*WORD_W-1:2*WORD_W];
                default: out_enq_v = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!empty) state_nxt = FIRST;
`ifdef ECHO_SER_HEADER_EN
            HDR:  if (xfer) state_nxt = W0;
`endif
            W0:   if (xfer) state_nxt = W1;
            W1:   if (xfer) state_nxt = W2;
            // Another message already waiting: start it without an idle gap
            W2:   if (xfer) state_nxt = (count > CW'(1)) ? FIRST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed bench for echo_indication_serializer with a message-level reference model.
// Header-specific cases are built only with ECHO_SER_HEADER_EN.
module tb_echo_indication_serializer;

    localparam int DEPTH  = 2;
    localparam int WORD_W = 32;
`ifdef ECHO_SER_HEADER_EN
    localparam int NW = 4;
    localparam int H  = 1;
`else
    localparam int NW = 3;
    localparam int H  = 0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        enq_ena = 1'b0;
    logic [95:0] enq_v = '0;
    logic        out_rdy = 1'b0;
    logic        pipe_rdy;
    logic        out_ena;
    logic [31:0] out_v;
    logic        out_last;

    echo_indication_serializer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pipe_enq__ENA (enq_ena),
        .pipe_enq_v    (enq_v),
        .pipe_enq__RDY (pipe_rdy),
        .out_enq__ENA  (out_ena),
        .out_enq_v     (out_v),
        .out_enq_last  (out_last),
        .out_enq__RDY  (out_rdy)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: queue of accepted messages plus position within the head message
    logic [95:0] mq[$];
    bit          busy = 0;
    int          idx  = 0;
    logic [15:0] mseq = '0;

    function automatic logic [31:0] model_word();
        int k;
        if (H == 1 && idx == 0) return {16'd3, mseq};
        k = idx - H;
        return mq[0][k*32 +: 32];
    endfunction

    always @(posedge CLK) begin
        int  c;
        bit  acc;
        cyc++;
        if (!nRST) begin
            mq.delete();
            busy = 0;
            idx  = 0;
            mseq = '0;
        end else begin
            c   = mq.size();
            acc = enq_ena && (c < DEPTH);
            if (busy && out_rdy) begin
                if (idx == NW - 1) begin
                    void'(mq.pop_front());
                    mseq = mseq + 16'd1;
                    busy = (c > 1);
                    idx  = 0;
                end else begin
                    idx++;
                end
            end else if (!busy && c != 0) begin
                busy = 1;
                idx  = 0;
            end
            if (acc) mq.push_back(enq_v);
        end
    end

    // Transfer log for the directed checks
    logic [31:0] lv[$];
    bit          ll[$];
    int          lc[$];
    bit          lr[$];

    initial begin
        bit live;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            live = nRST && busy;
            check("rdy",  64'(pipe_rdy), 64'(mq.size() != DEPTH));
            check("ena",  64'(out_ena),  64'(live && out_rdy));
            check("word", 64'(out_v),    live ? 64'(model_word()) : 64'd0);
            check("last", 64'(out_last), 64'(live && idx == NW - 1));
            if (out_ena) begin
                lv.push_back(out_v);
                ll.push_back(out_last);
                lc.push_back(cyc);
                lr.push_back(pipe_rdy);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_log(input int n);
        int b = 0;
        while (lv.size() < n && b < 60) begin
            tick();
            b++;
        end
        if (lv.size() < n) check("log_timeout", 64'(lv.size()), 64'(n));
    endtask

    task automatic send(input logic [31:0] v, input logic [31:0] m, input logic [31:0] t);
        enq_v   = {v, m, t};
        enq_ena = 1'b1;
        tick();
        enq_ena = 1'b0;
    endtask

    task automatic expect_msg(input int base, input logic [15:0] seq, input logic [31:0] t,
                              input logic [31:0] m, input logic [31:0] v, input bit consec);
        logic [31:0] exp_w [4];
        int          e;
        e = 0;
        if (H == 1) begin exp_w[e] = {16'd3, seq}; e++; end
        exp_w[e] = t; exp_w[e+1] = m; exp_w[e+2] = v;
        for (int k = 0; k < NW; k++) begin
            if (base + k >= lv.size()) begin
                check("msg_missing", 64'(lv.size()), 64'(base + k + 1));
            end else begin
                check("msg_word", 64'(lv[base+k]), 64'(exp_w[k]));
                check("msg_last", 64'(ll[base+k]), 64'(k == NW - 1));
                if (consec && k > 0) check("msg_gap", 64'(lc[base+k] - lc[base]), 64'(k));
            end
        end
    endtask

    initial begin
        int n0;
        bit r [3];

        // Reset
        nRST = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        check("rst_rdy",  64'(pipe_rdy), 64'd1);
        check("rst_ena",  64'(out_ena),  64'd0);
        check("rst_word", 64'(out_v),    64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        tick();
        nRST = 1'b1;
        tick();

        // Single message, downstream always ready
        out_rdy = 1'b1;
        n0 = lv.size();
        send(32'h33, 32'h22, 32'h1);
        wait_log(n0 + NW);
        expect_msg(n0, 16'd0, 32'h1, 32'h22, 32'h33, 1'b1);
        tick();

        // Downstream stalled: third back-to-back message refused
        out_rdy = 1'b0;
        n0 = lv.size();
        for (int i = 0; i < 3; i++) begin
            enq_v   = {32'h13 + 32'(i*16), 32'h12 + 32'(i*16), 32'h11 + 32'(i*16)};
            enq_ena = 1'b1;
            @(negedge CLK);
            r[i] = pipe_rdy;
            tick();
        end
        enq_ena = 1'b0;
        check("offer0_rdy", 64'(r[0]), 64'd1);
        check("offer1_rdy", 64'(r[1]), 64'd1);
        check("offer2_rdy", 64'(r[2]), 64'd0);
        repeat (3) tick();
        check("stall_no_ena", 64'(lv.size()), 64'(n0));

        // Drain the two queued messages with no gap
        out_rdy = 1'b1;
        wait_log(n0 + 2*NW);
        expect_msg(n0,      16'd1, 32'h11, 32'h12, 32'h13, 1'b1);
        expect_msg(n0 + NW, 16'd2, 32'h21, 32'h22, 32'h23, 1'b1);
        if (lv.size() >= n0 + NW + 1) begin
            check("boundary_gap",  64'(lc[n0+NW] - lc[n0+NW-1]), 64'd1);
            check("rdy_at_last",   64'(lr[n0+NW-1]), 64'd0);
            check("rdy_after_pop", 64'(lr[n0+NW]),   64'd1);
        end else begin
            check("drain_len", 64'(lv.size()), 64'(n0 + NW + 1));
        end
        tick();

        // Downstream ready toggling mid-message
        out_rdy = 1'b0;
        n0 = lv.size();
        send(32'h43, 32'h42, 32'h41);
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            out_rdy = ~out_rdy;
            tick();
        end
        out_rdy = 1'b1;
        wait_log(n0 + NW);
        expect_msg(n0, 16'd3, 32'h41, 32'h42, 32'h43, 1'b0);
        tick();

        // Reset after the W0 transfer abandons the message
        n0 = lv.size();
        send(32'h53, 32'h52, 32'h51);
        wait_log(n0 + H + 1);
        nRST = 1'b0;
        @(negedge CLK);
        check("midrst_ena",  64'(out_ena), 64'd0);
        check("midrst_word", 64'(out_v),   64'd0);
        tick();
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        check("postrst_rdy", 64'(pipe_rdy), 64'd1);
        check("postrst_ena", 64'(out_ena),  64'd0);
        repeat (4) tick();
        check("no_resume", 64'(lv.size()), 64'(n0 + H + 1));
        n0 = lv.size();
        send(32'h63, 32'h62, 32'h61);
        wait_log(n0 + NW);
        expect_msg(n0, 16'd0, 32'h61, 32'h62, 32'h63, 1'b1);
        tick();

`ifdef ECHO_SER_HEADER_EN
        // Header sequence from reset and across the 16-bit wrap
        nRST = 1'b0;
        repeat (2) tick();
        nRST = 1'b1;
        n0 = lv.size();
        send(32'h73, 32'h72, 32'h71);
        send(32'h83, 32'h82, 32'h81);
        wait_log(n0 + 2*NW);
        if (lv.size() >= n0 + 2*NW) begin
            check("hdr_seq0", 64'(lv[n0]),      64'h0003_0000);
            check("hdr_seq1", 64'(lv[n0+NW]),   64'h0003_0001);
        end
        repeat (3) tick();
        force dut.seq = 16'hFFFF;
        mseq = 16'hFFFF;
        tick();
        release dut.seq;
        n0 = lv.size();
        send(32'h93, 32'h92, 32'h91);
        send(32'hA3, 32'hA2, 32'hA1);
        wait_log(n0 + 2*NW);
        if (lv.size() >= n0 + 2*NW) begin
            check("hdr_ffff", 64'(lv[n0]),    64'h0003_FFFF);
            check("hdr_wrap", 64'(lv[n0+NW]), 64'h0003_0000);
        end
        tick();
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
